hazard_ctrl: RTL and testbench
==============================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter: STALL_CYCLES, default 1, number of bubble cycles per load-use hazard; legal range 1..3.
REQ-002 clk  in  1  rising-edge clock.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 id_addr_rs  in  `GRP_ADDR_WIDTH  rs address of the instruction in ID.
REQ-005 id_addr_rt  in  `GRP_ADDR_WIDTH  rt address of the instruction in ID.
REQ-006 id_uses_rs / id_uses_rt  in  1 each  ID instruction reads rs / rt.
REQ-007 id_is_halt  in  1  ID holds a halt instruction.
REQ-008 ex_reg_write_enable  in  1  EX instruction writes the register file.
REQ-009 ex_wb_res_mux  in  2  EX write-back source select.
REQ-010 ex_dest_addr  in  `GRP_ADDR_WIDTH  EX destination (EX dest-mux output).
REQ-011 mem_branch_taken  in  1  MEM-stage branch/jump resolved taken.
REQ-012 resume  in  1  leave HALT.
REQ-013 pc_write_enable  out  1  PC may update.
REQ-014 ifid_write_enable  out  1  IF/ID register may load.
REQ-015 ifid_flush / idex_flush / exmem_flush  out  1 each  load a bubble (all controls 0) into that pipeline register.
REQ-016 halted  out  1  controller is in HALT.
REQ-017 stall_count  out  16  hazard-stall cycle counter.

Function
REQ-018 Hazard = ex_reg_write_enable & (ex_wb_res_mux == WB_SRC_MEM) & ((id_uses_rs & id_addr_rs == ex_dest_addr) | (id_uses_rt & id_addr_rt == ex_dest_addr)).
REQ-019 States: RUN, STALL, HALT; 2-bit remaining-bubble counter bcnt.
REQ-020 Outputs are combinational from state and current inputs (zero-latency), state/counters update on clk.
REQ-021 Priority, highest first: rst, mem_branch_taken, current STALL, hazard, id_is_halt, normal.
REQ-022 Branch (any state): pc_write_enable=1, ifid_write_enable=1, ifid_flush=idex_flush=exmem_flush=1; next state RUN, bcnt=0; stall_count unchanged.
REQ-023 RUN & hazard: pc_write_enable=0, ifid_write_enable=0, idex_flush=1; next STALL with bcnt=STALL_CYCLES-1 if STALL_CYCLES>1, else stay RUN.
REQ-024 STALL: same outputs as REQ-023 regardless of hazard; bcnt decrements; bcnt==1 at edge -> RUN next cycle.
REQ-025 RUN & id_is_halt & no hazard: pc_write_enable=0, ifid_write_enable=0, idex_flush=1; next HALT.
REQ-026 HALT: pc_write_enable=0, ifid_write_enable=0, idex_flush=1, halted=1; resume -> RUN next cycle (halted=0 from that cycle); resume outside HALT ignored.
REQ-027 RUN normal: pc_write_enable=1, ifid_write_enable=1, all flushes 0, halted=0.
REQ-028 stall_count increments by 1 on every edge where a REQ-023/REQ-024 stall cycle is active; saturates at 16'hFFFF; HALT cycles not counted.
REQ-029 Branch during STALL aborts remaining bubbles; branch during HALT cancels halt.

Reset
REQ-030 rst high at edge: state=RUN, bcnt=0, stall_count=0.
REQ-031 While rst high, outputs forced: pc_write_enable=0, ifid_write_enable=0, all flushes=1, halted=0; rst mid-STALL or mid-HALT discards all pending state.

Structure
REQ-032 WB_SRC_MEM (2'b01) and state encodings (RUN=0, STALL=1, HALT=2) live in lapido_defs.v; `GRP_ADDR_WIDTH taken from it.
REQ-033 One sub-module: hazard_detect (combinational REQ-018 comparator); FSM and counters in hazard_ctrl.

Verification
REQ-034 EX load dest=3, wb_mux=WB_SRC_MEM; ID rs=3 uses_rs=1, STALL_CYCLES=1 -> one cycle pc_we=0, idex_flush=1; stall_count=1; RUN next.
REQ-035 STALL_CYCLES=3, same hazard -> exactly 3 consecutive stall cycles, stall_count=3, then pc_we=1.
REQ-036 Hazard held, STALL_CYCLES=3, mem_branch_taken in second stall cycle -> that cycle all three flushes=1, pc_we=1; RUN next; stall_count=1.
REQ-037 id_is_halt=1 -> halted=1 next cycle, pc_we=0 held 10 cycles, stall_count unchanged; resume=1 -> halted=0 and pc_we=1 next cycle.
REQ-038 EX load dest=3 but id_uses_rs=0, rt=4 -> no stall; ex_wb_res_mux=2'b00 with matching rs -> no stall.
REQ-039 Preload stall_count to 16'hFFFE via hazards, two more stalls -> holds 16'hFFFF; rst during STALL -> state RUN, stall_count=0, outputs forced per REQ-031.

Source files
------------

// File: rtl/hazard_ctrl_pkg.sv
// Shared constants and types for the load-use / halt hazard controller.
package hazard_ctrl_pkg;
    localparam int         GRP_ADDR_WIDTH = 5;
    localparam logic [1:0] WB_SRC_MEM     = 2'b01;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STALL = 2'd1,
        ST_HALT  = 2'd2
    } state_e;
endpackage

// File: rtl/hazard_detect.sv
// Combinational load-use comparator: EX holds a load whose destination the ID instruction reads.
module hazard_detect
    import hazard_ctrl_pkg::*;
(
    input  logic [GRP_ADDR_WIDTH-1:0] i_id_addr_rs,
    input  logic [GRP_ADDR_WIDTH-1:0] i_id_addr_rt,
    input  logic                      i_id_uses_rs,
    input  logic                      i_id_uses_rt,
    input  logic                      i_ex_reg_write_enable,
    input  logic [1:0]                i_ex_wb_res_mux,
    input  logic [GRP_ADDR_WIDTH-1:0] i_ex_dest_addr,
    output logic                      o_hazard
);
    logic w_ex_is_load;
    logic w_rs_match;
    logic w_rt_match;

    assign w_ex_is_load = i_ex_reg_write_enable && (i_ex_wb_res_mux == WB_SRC_MEM);
    assign w_rs_match   = i_id_uses_rs && (i_id_addr_rs == i_ex_dest_addr);
    assign w_rt_match   = i_id_uses_rt && (i_id_addr_rt == i_ex_dest_addr);
    assign o_hazard     = w_ex_is_load && (w_rs_match || w_rt_match);
endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use bubbles, halt/resume and branch flush,
// with a saturating count of hazard-stall cycles.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int STALL_CYCLES = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [GRP_ADDR_WIDTH-1:0] id_addr_rs,
    input  logic [GRP_ADDR_WIDTH-1:0] id_addr_rt,
    input  logic                      id_uses_rs,
    input  logic                      id_uses_rt,
    input  logic                      id_is_halt,
    input  logic                      ex_reg_write_enable,
    input  logic [1:0]                ex_wb_res_mux,
    input  logic [GRP_ADDR_WIDTH-1:0] ex_dest_addr,
    input  logic                      mem_branch_taken,
    input  logic                      resume,
    output logic                      pc_write_enable,
    output logic                      ifid_write_enable,
    output logic                      ifid_flush,
    output logic                      idex_flush,
    output logic                      exmem_flush,
    output logic                      halted,
    output logic [15:0]               stall_count
);
    // Bubbles still owed after the first stall cycle, which is spent in RUN.
    localparam logic [1:0] BCNT_INIT = 2'(STALL_CYCLES - 1);

    state_e      r_state;
    state_e      w_next_state;
    logic [1:0]  r_bcnt;
    logic [1:0]  w_next_bcnt;
    logic [15:0] r_stall_count;
    logic        w_hazard;
    logic        w_stall_active;

    hazard_detect u_detect (
        .i_id_addr_rs          (id_addr_rs),
        .i_id_addr_rt          (id_addr_rt),
        .i_id_uses_rs          (id_uses_rs),
        .i_id_uses_rt          (id_uses_rt),
        .i_ex_reg_write_enable (ex_reg_write_enable),
        .i_ex_wb_res_mux       (ex_wb_res_mux),
        .i_ex_dest_addr        (ex_dest_addr),
        .o_hazard              (w_hazard)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_RUN;
            r_bcnt  <= 2'd0;
        end else begin
            r_state <= w_next_state;
            r_bcnt  <= w_next_bcnt;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_next_bcnt  = r_bcnt;
        if (mem_branch_taken) begin
            w_next_state = ST_RUN;
            w_next_bcnt  = 2'd0;
        end else begin
            case (r_state)
                ST_STALL: begin
                    if (r_bcnt <= 2'd1) begin
                        w_next_state = ST_RUN;
                        w_next_bcnt  = 2'd0;
                    end else begin
                        w_next_bcnt = r_bcnt - 2'd1;
                    end
                end
                ST_RUN: begin
                    if (w_hazard) begin
                        if (STALL_CYCLES > 1) begin
                            w_next_state = ST_STALL;
                            w_next_bcnt  = BCNT_INIT;
                        end
                    end else if (id_is_halt) begin
                        w_next_state = ST_HALT;
                    end
                end
                ST_HALT: begin
                    if (resume) w_next_state = ST_RUN;
                end
                default: begin
                    w_next_state = ST_RUN;
                    w_next_bcnt  = 2'd0;
                end
            endcase
        end
    end

    always_comb begin
        pc_write_enable   = 1'b1;
        ifid_write_enable = 1'b1;
        ifid_flush        = 1'b0;
        idex_flush        = 1'b0;
        exmem_flush       = 1'b0;
        halted            = 1'b0;
        w_stall_active    = 1'b0;
        if (rst) begin
            pc_write_enable   = 1'b0;
            ifid_write_enable = 1'b0;
            ifid_flush        = 1'b1;
            idex_flush        = 1'b1;
            exmem_flush       = 1'b1;
        end else if (mem_branch_taken) begin
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
        end else begin
            case (r_state)
                ST_STALL: begin
                    pc_write_enable   = 1'b0;
                    ifid_write_enable = 1'b0;
                    idex_flush        = 1'b1;
                    w_stall_active    = 1'b1;
                end
                ST_HALT: begin
                    pc_write_enable   = 1'b0;
                    ifid_write_enable = 1'b0;
                    idex_flush        = 1'b1;
                    halted            = 1'b1;
                end
                default: begin
                    if (w_hazard || id_is_halt) begin
                        pc_write_enable   = 1'b0;
                        ifid_write_enable = 1'b0;
                        idex_flush        = 1'b1;
                        w_stall_active    = w_hazard;
                    end
                end
            endcase
        end
    end

    // Halt cycles hold the pipeline too but are deliberately not counted.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_count <= 16'd0;
        end else if (w_stall_active && (r_stall_count != 16'hFFFF)) begin
            r_stall_count <= r_stall_count + 16'd1;
        end
    end

    assign stall_count = r_stall_count;
endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: two instances (1 and 3 bubbles) share one stimulus stream.
module tb_hazard_ctrl;
    import hazard_ctrl_pkg::*;

    localparam logic [5:0] NORMAL = 6'b110000;  // {pc_we, ifid_we, ifid_f, idex_f, exmem_f, halted}
    localparam logic [5:0] STALLO = 6'b000100;
    localparam logic [5:0] HALTO  = 6'b000101;
    localparam logic [5:0] BRANCH = 6'b111110;
    localparam logic [5:0] RSTO   = 6'b001110;

    logic                      clk;
    logic                      rst;
    logic [GRP_ADDR_WIDTH-1:0] id_addr_rs, id_addr_rt, ex_dest_addr;
    logic                      id_uses_rs, id_uses_rt, id_is_halt;
    logic                      ex_reg_write_enable, mem_branch_taken, resume;
    logic [1:0]                ex_wb_res_mux;

    logic        pc1, ifid1, iff1, idf1, exf1, h1;
    logic        pc3, ifid3, iff3, idf3, exf3, h3;
    logic [15:0] sc1, sc3;
    logic [5:0]  o1, o3;

    int vecs = 0;
    int errs = 0;

    assign o1 = {pc1, ifid1, iff1, idf1, exf1, h1};
    assign o3 = {pc3, ifid3, iff3, idf3, exf3, h3};

    hazard_ctrl #(.STALL_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst),
        .id_addr_rs(id_addr_rs), .id_addr_rt(id_addr_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_is_halt(id_is_halt),
        .ex_reg_write_enable(ex_reg_write_enable), .ex_wb_res_mux(ex_wb_res_mux),
        .ex_dest_addr(ex_dest_addr), .mem_branch_taken(mem_branch_taken), .resume(resume),
        .pc_write_enable(pc1), .ifid_write_enable(ifid1), .ifid_flush(iff1),
        .idex_flush(idf1), .exmem_flush(exf1), .halted(h1), .stall_count(sc1)
    );

    hazard_ctrl #(.STALL_CYCLES(3)) dut3 (
        .clk(clk), .rst(rst),
        .id_addr_rs(id_addr_rs), .id_addr_rt(id_addr_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_is_halt(id_is_halt),
        .ex_reg_write_enable(ex_reg_write_enable), .ex_wb_res_mux(ex_wb_res_mux),
        .ex_dest_addr(ex_dest_addr), .mem_branch_taken(mem_branch_taken), .resume(resume),
        .pc_write_enable(pc3), .ifid_write_enable(ifid3), .ifid_flush(iff3),
        .idex_flush(idf3), .exmem_flush(exf3), .halted(h3), .stall_count(sc3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs;
        id_addr_rs = '0; id_addr_rt = '0; ex_dest_addr = '0;
        id_uses_rs = 1'b0; id_uses_rt = 1'b0; id_is_halt = 1'b0;
        ex_reg_write_enable = 1'b0; ex_wb_res_mux = 2'b00;
        mem_branch_taken = 1'b0; resume = 1'b0;
    endtask

    task automatic set_load_hazard;
        ex_reg_write_enable = 1'b1; ex_wb_res_mux = WB_SRC_MEM; ex_dest_addr = 5'd3;
        id_addr_rs = 5'd3; id_uses_rs = 1'b1;
    endtask

    task automatic do_reset;
        clear_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset;
        clear_inputs();
        rst = 1'b1;
        #2;
        vecs++; if (o1 !== RSTO) begin errs++; $display("FAIL rst_out1: got %b exp %b", o1, RSTO); end
        vecs++; if (o3 !== RSTO) begin errs++; $display("FAIL rst_out3: got %b exp %b", o3, RSTO); end
        tick();
        rst = 1'b0;
        #2;
        vecs++; if (o1 !== NORMAL) begin errs++; $display("FAIL post_rst_out1: got %b exp %b", o1, NORMAL); end
        vecs++; if (o3 !== NORMAL) begin errs++; $display("FAIL post_rst_out3: got %b exp %b", o3, NORMAL); end
        vecs++; if (sc1 !== 16'd0) begin errs++; $display("FAIL post_rst_sc1: got %0d exp 0", sc1); end
        vecs++; if (sc3 !== 16'd0) begin errs++; $display("FAIL post_rst_sc3: got %0d exp 0", sc3); end
    endtask

    task automatic test_load_use;
        do_reset();
        set_load_hazard();
        #2;
        vecs++; if (o1 !== STALLO) begin errs++; $display("FAIL lu_first1: got %b exp %b", o1, STALLO); end
        vecs++; if (o3 !== STALLO) begin errs++; $display("FAIL lu_first3: got %b exp %b", o3, STALLO); end
        tick();
        clear_inputs();
        #2;
        vecs++; if (o1 !== NORMAL) begin errs++; $display("FAIL lu_run1: got %b exp %b", o1, NORMAL); end
        vecs++; if (sc1 !== 16'd1) begin errs++; $display("FAIL lu_sc1: got %0d exp 1", sc1); end
        vecs++; if (o3 !== STALLO) begin errs++; $display("FAIL lu_b2_3: got %b exp %b", o3, STALLO); end
        tick();
        #2;
        vecs++; if (o3 !== STALLO) begin errs++; $display("FAIL lu_b3_3: got %b exp %b", o3, STALLO); end
        vecs++; if (sc3 !== 16'd2) begin errs++; $display("FAIL lu_sc3_mid: got %0d exp 2", sc3); end
        tick();
        #2;
        vecs++; if (o3 !== NORMAL) begin errs++; $display("FAIL lu_run3: got %b exp %b", o3, NORMAL); end
        vecs++; if (sc3 !== 16'd3) begin errs++; $display("FAIL lu_sc3: got %0d exp 3", sc3); end
        vecs++; if (sc1 !== 16'd1) begin errs++; $display("FAIL lu_sc1_hold: got %0d exp 1", sc1); end
    endtask

    task automatic test_no_hazard;
        do_reset();
        ex_reg_write_enable = 1'b1; ex_wb_res_mux = WB_SRC_MEM; ex_dest_addr = 5'd3;
        id_addr_rs = 5'd3; id_uses_rs = 1'b0; id_addr_rt = 5'd4; id_uses_rt = 1'b1;
        #2;
        vecs++; if (o1 !== NORMAL) begin errs++; $display("FAIL nh_unused_rs: got %b exp %b", o1, NORMAL); end
        id_uses_rs = 1'b1; ex_wb_res_mux = 2'b00;
        #2;
        vecs++; if (o1 !== NORMAL) begin errs++; $display("FAIL nh_alu_src: got %b exp %b", o1, NORMAL); end
        ex_wb_res_mux = WB_SRC_MEM; ex_reg_write_enable = 1'b0;
        #2;
        vecs++; if (o1 !== NORMAL) begin errs++; $display("FAIL nh_no_we: got %b exp %b", o1, NORMAL); end
        ex_reg_write_enable = 1'b1; id_uses_rs = 1'b0; id_addr_rt = 5'd3;
        #2;
        vecs++; if (o1 !== STALLO) begin errs++; $display("FAIL nh_rt_match: got %b exp %b", o1, STALLO); end
        tick();
        clear_inputs();
        #2;
        vecs++; if (sc1 !== 16'd1) begin errs++; $display("FAIL nh_sc1: got %0d exp 1", sc1); end
    endtask

    task automatic test_branch_in_stall;
        do_reset();
        set_load_hazard();
        tick();
        mem_branch_taken = 1'b1;
        #2;
        vecs++; if (o3 !== BRANCH) begin errs++; $display("FAIL br_stall3: got %b exp %b", o3, BRANCH); end
        vecs++; if (o1 !== BRANCH) begin errs++; $display("FAIL br_stall1: got %b exp %b", o1, BRANCH); end
        tick();
        clear_inputs();
        #2;
        vecs++; if (o3 !== NORMAL) begin errs++; $display("FAIL br_run3: got %b exp %b", o3, NORMAL); end
        vecs++; if (sc3 !== 16'd1) begin errs++; $display("FAIL br_sc3: got %0d exp 1", sc3); end
        vecs++; if (sc1 !== 16'd1) begin errs++; $display("FAIL br_sc1: got %0d exp 1", sc1); end
    endtask

    task automatic test_halt;
        do_reset();
        id_is_halt = 1'b1;
        #2;
        vecs++; if (o1 !== STALLO) begin errs++; $display("FAIL halt_enter: got %b exp %b", o1, STALLO); end
        tick();
        id_is_halt = 1'b0;
        for (int i = 0; i < 10; i++) begin
            #2;
            vecs++; if (o1 !== HALTO) begin errs++; $display("FAIL halt_hold%0d: got %b exp %b", i, o1, HALTO); end
            tick();
        end
        vecs++; if (sc1 !== 16'd0) begin errs++; $display("FAIL halt_sc1: got %0d exp 0", sc1); end
        resume = 1'b1;
        #2;
        vecs++; if (o3 !== HALTO) begin errs++; $display("FAIL halt_resume_cyc: got %b exp %b", o3, HALTO); end
        tick();
        resume = 1'b0;
        #2;
        vecs++; if (o1 !== NORMAL) begin errs++; $display("FAIL halt_after_resume: got %b exp %b", o1, NORMAL); end
        resume = 1'b1;
        tick();
        resume = 1'b0;
        #2;
        vecs++; if (o1 !== NORMAL) begin errs++; $display("FAIL resume_in_run: got %b exp %b", o1, NORMAL); end
        id_is_halt = 1'b1;
        tick();
        id_is_halt = 1'b0;
        mem_branch_taken = 1'b1;
        #2;
        vecs++; if (o1 !== BRANCH) begin errs++; $display("FAIL halt_branch: got %b exp %b", o1, BRANCH); end
        tick();
        mem_branch_taken = 1'b0;
        #2;
        vecs++; if (o1 !== NORMAL) begin errs++; $display("FAIL halt_cancelled: got %b exp %b", o1, NORMAL); end
    endtask

    task automatic test_saturate_and_reset;
        do_reset();
        set_load_hazard();
        repeat (65534) tick();
        #2;
        vecs++; if (sc1 !== 16'hFFFE) begin errs++; $display("FAIL sat_pre1: got %h exp fffe", sc1); end
        vecs++; if (sc3 !== 16'hFFFE) begin errs++; $display("FAIL sat_pre3: got %h exp fffe", sc3); end
        tick();
        #2;
        vecs++; if (sc1 !== 16'hFFFF) begin errs++; $display("FAIL sat_top1: got %h exp ffff", sc1); end
        tick();
        #2;
        vecs++; if (sc1 !== 16'hFFFF) begin errs++; $display("FAIL sat_hold1: got %h exp ffff", sc1); end
        vecs++; if (sc3 !== 16'hFFFF) begin errs++; $display("FAIL sat_hold3: got %h exp ffff", sc3); end
        clear_inputs();
        repeat (3) tick();
        set_load_hazard();
        tick();
        clear_inputs();
        #2;
        vecs++; if (o3 !== STALLO) begin errs++; $display("FAIL mid_stall3: got %b exp %b", o3, STALLO); end
        rst = 1'b1;
        #2;
        vecs++; if (o3 !== RSTO) begin errs++; $display("FAIL rst_in_stall3: got %b exp %b", o3, RSTO); end
        tick();
        rst = 1'b0;
        #2;
        vecs++; if (o3 !== NORMAL) begin errs++; $display("FAIL rst_drop3: got %b exp %b", o3, NORMAL); end
        vecs++; if (sc3 !== 16'd0) begin errs++; $display("FAIL rst_sc3: got %0d exp 0", sc3); end
        vecs++; if (sc1 !== 16'd0) begin errs++; $display("FAIL rst_sc1: got %0d exp 0", sc1); end
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        test_reset();
        test_load_use();
        test_no_hazard();
        test_branch_in_stall();
        test_halt();
        test_saturate_and_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
